// File: rtl/rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rd_pkg
// Description : Shared definitions for the read-line pacer: buffer word
//               width, tag width, the pacer state encoding and the
//               beats-per-line helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rd_pkg;

    localparam int RAM_WIDTH = 128;
    localparam int TAG_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FSYNC    = 3'd1,
        ST_PREFETCH = 3'd2,
        ST_LINE     = 3'd3,
        ST_GAP      = 3'd4,
        ST_DRAIN    = 3'd5
    } rd_state_e;

    // Number of RAM_WIDTH-bit buffer beats that make up one video line.
    function automatic int beats_per_line(input int h_num, input int pix_width);
        return (h_num * pix_width) / RAM_WIDTH;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rd_line_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rd_line_fifo
// Description : Synchronous first-word-fall-through FIFO. The head entry is
//               visible on rd_data_o whenever empty_o is low. A push and a
//               pop in the same cycle are accepted even when full.
// Ports       : clk_i      - clock
//               rstn_i     - synchronous active-low reset (flushes contents)
//               wr_en_i    - push request
//               wr_data_i  - push data
//               rd_en_i    - pop request (ignored when empty)
//               rd_data_o  - head entry
//               empty_o    - no entries
//               full_o     - DEPTH entries
//               level_o    - current number of entries
// Revision    : 1.0 - initial release
// ============================================================================
module rd_line_fifo #(
    parameter int WIDTH = 131,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = rd_en_i && (level_q != '0);
    // A pop frees the slot the full FIFO would otherwise refuse.
    assign w_push = wr_en_i && ((level_q != LW'(DEPTH)) || w_pop);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign empty_o   = (level_q == '0);
    assign full_o    = (level_q == LW'(DEPTH));
    assign level_o   = level_q;

endmodule
`default_nettype wire

// File: rtl/rd_line_pacer.sv
`default_nettype none
// ============================================================================
// Module      : rd_line_pacer
// Description : Paces reads out of the DDR frame read buffer (frame sync,
//               first-line prefetch wait, per-line gaps, FIFO credit) and
//               re-emits captured beats as a tagged valid/ready stream.
// Ports       : vout_clk/vout_rstn     - clock, synchronous active-low reset
//               frame_start/busy/frame_done - host control
//               rd_fsync/rd_en         - read buffer control
//               vout_de/vout_data      - read buffer beats (2 cycles after rd_en)
//               m_data/m_valid/m_ready/m_sof/m_eol/m_eof - output stream
//               line_cnt               - lines fully issued this frame
//               ovf_err                - sticky capture overflow
// Revision    : 1.0 - initial release
// ============================================================================
module rd_line_pacer
    import rd_pkg::*;
#(
    parameter int H_NUM      = 1920,
    parameter int V_NUM      = 1080,
    parameter int PIX_WIDTH  = 24,
    parameter int FSYNC_HOLD = 8,
    parameter int FIRST_WAIT = 2048,
    parameter int LINE_GAP   = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 vout_clk,
    input  logic                 vout_rstn,
    input  logic                 frame_start,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 rd_fsync,
    output logic                 rd_en,
    input  logic                 vout_de,
    input  logic [RAM_WIDTH-1:0] vout_data,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_sof,
    output logic                 m_eol,
    output logic                 m_eof,
    output logic [11:0]          line_cnt,
    output logic                 ovf_err
);

    localparam int BEATS    = beats_per_line(H_NUM, PIX_WIDTH);
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int MAX_WAIT = (FSYNC_HOLD > FIRST_WAIT)
                              ? ((FSYNC_HOLD > LINE_GAP) ? FSYNC_HOLD : LINE_GAP)
                              : ((FIRST_WAIT > LINE_GAP) ? FIRST_WAIT : LINE_GAP);
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);
    localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int FW       = RAM_WIDTH + TAG_W;

    localparam logic [CNT_W-1:0]  FSYNC_LAST = CNT_W'(FSYNC_HOLD - 1);
    localparam logic [CNT_W-1:0]  FIRST_LAST = CNT_W'(FIRST_WAIT - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(LINE_GAP - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BEATS - 1);
    localparam logic [11:0]       LINE_LAST  = 12'(V_NUM - 1);

    if ((H_NUM * PIX_WIDTH) % RAM_WIDTH != 0 || BEATS < 1) begin : g_chk_beats
        $error("rd_line_pacer: H_NUM*PIX_WIDTH must be a multiple of %0d", RAM_WIDTH);
    end
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("rd_line_pacer: FIFO_DEPTH must be a power of 2 and at least 4");
    end
    if (V_NUM < 1 || V_NUM > 4095 || FSYNC_HOLD < 4) begin : g_chk_frame
        $error("rd_line_pacer: V_NUM must be 1..4095 and FSYNC_HOLD at least 4");
    end

    rd_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [11:0]       line_q, line_d;
    logic [1:0]        out_q, out_d;
    logic [BEAT_W-1:0] rx_beat_q, rx_beat_d;
    logic [11:0]       rx_line_q, rx_line_d;
    logic              ovf_q, ovf_d;

    logic              w_start;
    logic              w_credit;
    logic              w_rd_en;
    logic              w_done;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [LVL_W-1:0]  w_level;
    logic              w_sof, w_eol, w_eof;
    logic [FW-1:0]     w_head;

    assign w_start  = (state_q == ST_IDLE) && frame_start;
    // Reserve a slot for every beat already requested but not yet returned.
    assign w_credit = (int'(w_level) + int'(out_q) + 1) <= FIFO_DEPTH;
    assign w_pop    = !w_empty && m_ready;
    assign w_push   = vout_de && (!w_full || w_pop);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        line_d  = line_q;
        w_rd_en = 1'b0;
        w_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_FSYNC;
                    cnt_d   = '0;
                    beat_d  = '0;
                    line_d  = '0;
                end
            end
            ST_FSYNC: begin
                if (cnt_q == FSYNC_LAST) begin
                    cnt_d   = '0;
                    state_d = (FIRST_WAIT == 0) ? ST_LINE : ST_PREFETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PREFETCH: begin
                if (cnt_q == FIRST_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_LINE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LINE: begin
                if (w_credit) begin
                    w_rd_en = 1'b1;
                    if (beat_q == BEAT_LAST) begin
                        beat_d = '0;
                        line_d = line_q + 12'd1;
                        if (line_q == LINE_LAST) begin
                            state_d = ST_DRAIN;
                        end else if (LINE_GAP != 0) begin
                            state_d = ST_GAP;
                            cnt_d   = '0;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_LINE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (out_q == 2'd0 && w_empty) begin
                    w_done  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_d     = out_q;
        rx_beat_d = rx_beat_q;
        rx_line_d = rx_line_q;
        ovf_d     = ovf_q;
        case ({w_rd_en, vout_de})
            2'b10:   out_d = out_q + 2'd1;
            // Saturate so a stray beat cannot wrap the in-flight count.
            2'b01:   out_d = (out_q == 2'd0) ? 2'd0 : out_q - 2'd1;
            default: out_d = out_q;
        endcase
        if (w_start) begin
            rx_beat_d = '0;
            rx_line_d = '0;
            ovf_d     = 1'b0;
        end else begin
            // Tag counters follow stored beats only, so a dropped beat
            // does not shift the tags of the beats after it.
            if (w_push) begin
                if (rx_beat_q == BEAT_LAST) begin
                    rx_beat_d = '0;
                    rx_line_d = (rx_line_q == LINE_LAST) ? 12'd0 : rx_line_q + 12'd1;
                end else begin
                    rx_beat_d = rx_beat_q + BEAT_W'(1);
                end
            end
            if (vout_de && w_full && !w_pop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge vout_clk) begin
        if (!vout_rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            beat_q    <= '0;
            line_q    <= '0;
            out_q     <= '0;
            rx_beat_q <= '0;
            rx_line_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            beat_q    <= beat_d;
            line_q    <= line_d;
            out_q     <= out_d;
            rx_beat_q <= rx_beat_d;
            rx_line_q <= rx_line_d;
            ovf_q     <= ovf_d;
        end
    end

    assign w_sof = (rx_beat_q == '0) && (rx_line_q == 12'd0);
    assign w_eol = (rx_beat_q == BEAT_LAST);
    assign w_eof = w_eol && (rx_line_q == LINE_LAST);

    rd_line_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (vout_clk),
        .rstn_i    (vout_rstn),
        .wr_en_i   (w_push),
        .wr_data_i ({w_sof, w_eol, w_eof, vout_data}),
        .rd_en_i   (m_ready),
        .rd_data_o (w_head),
        .empty_o   (w_empty),
        .full_o    (w_full),
        .level_o   (w_level)
    );

    // Head entry is masked while empty so the stream idles at zero.
    assign m_valid    = !w_empty;
    assign m_data     = m_valid ? w_head[RAM_WIDTH-1:0] : '0;
    assign m_sof      = m_valid && w_head[FW-1];
    assign m_eol      = m_valid && w_head[FW-2];
    assign m_eof      = m_valid && w_head[FW-3];

    assign busy       = (state_q != ST_IDLE);
    assign frame_done = w_done;
    assign rd_fsync   = (state_q == ST_FSYNC);
    assign rd_en      = w_rd_en;
    assign line_cnt   = line_q;
    assign ovf_err    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_rd_line_pacer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rd_line_pacer
// Description : Directed bench for rd_line_pacer. Three instances cover the
//               basic frame (gap 4, depth 16), backpressure (depth 4) and
//               gap-free pacing (8 lines, depth 16). The read buffer is
//               modelled as rd_en delayed by two cycles carrying a beat index.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rd_line_pacer;

    logic         clk;
    logic [2:0]   rstn;
    logic [2:0]   fstart;
    logic [2:0]   mready;
    logic [2:0]   inj;
    logic [2:0]   busy, done, fsync, rden, de, mvalid, msof, meol, meof, ovf;
    logic [2:0]   p1, p2;
    logic [127:0] vdata [3];
    logic [127:0] mdata [3];
    logic [11:0]  lcnt  [3];

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign de = p2 | inj;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rstn[i]) begin
                p1[i]    <= 1'b0;
                p2[i]    <= 1'b0;
                vdata[i] <= '0;
            end else begin
                p1[i] <= rden[i];
                p2[i] <= p1[i];
                if (fsync[i]) vdata[i] <= '0;
                else if (p2[i]) vdata[i] <= vdata[i] + 128'd1;
            end
        end
    end

    rd_line_pacer #(.H_NUM(32), .V_NUM(4), .PIX_WIDTH(24), .FSYNC_HOLD(8),
                    .FIRST_WAIT(16), .LINE_GAP(4), .FIFO_DEPTH(16)) u_dut0 (
        .vout_clk(clk), .vout_rstn(rstn[0]), .frame_start(fstart[0]), .busy(busy[0]),
        .frame_done(done[0]), .rd_fsync(fsync[0]), .rd_en(rden[0]), .vout_de(de[0]),
        .vout_data(vdata[0]), .m_data(mdata[0]), .m_valid(mvalid[0]), .m_ready(mready[0]),
        .m_sof(msof[0]), .m_eol(meol[0]), .m_eof(meof[0]), .line_cnt(lcnt[0]), .ovf_err(ovf[0]));

    rd_line_pacer #(.H_NUM(32), .V_NUM(4), .PIX_WIDTH(24), .FSYNC_HOLD(8),
                    .FIRST_WAIT(16), .LINE_GAP(4), .FIFO_DEPTH(4)) u_dut1 (
        .vout_clk(clk), .vout_rstn(rstn[1]), .frame_start(fstart[1]), .busy(busy[1]),
        .frame_done(done[1]), .rd_fsync(fsync[1]), .rd_en(rden[1]), .vout_de(de[1]),
        .vout_data(vdata[1]), .m_data(mdata[1]), .m_valid(mvalid[1]), .m_ready(mready[1]),
        .m_sof(msof[1]), .m_eol(meol[1]), .m_eof(meof[1]), .line_cnt(lcnt[1]), .ovf_err(ovf[1]));

    rd_line_pacer #(.H_NUM(32), .V_NUM(8), .PIX_WIDTH(24), .FSYNC_HOLD(8),
                    .FIRST_WAIT(16), .LINE_GAP(0), .FIFO_DEPTH(16)) u_dut2 (
        .vout_clk(clk), .vout_rstn(rstn[2]), .frame_start(fstart[2]), .busy(busy[2]),
        .frame_done(done[2]), .rd_fsync(fsync[2]), .rd_en(rden[2]), .vout_de(de[2]),
        .vout_data(vdata[2]), .m_data(mdata[2]), .m_valid(mvalid[2]), .m_ready(mready[2]),
        .m_sof(msof[2]), .m_eol(meol[2]), .m_eof(meof[2]), .line_cnt(lcnt[2]), .ovf_err(ovf[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 3'b000; fstart = 3'b000; mready = 3'b111; inj = 3'b000;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy[i] !== 1'b0 || done[i] !== 1'b0 || fsync[i] !== 1'b0 || rden[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl[%0d] busy=%b done=%b fsync=%b rd_en=%b, want all 0",
                         i, busy[i], done[i], fsync[i], rden[i]);
            end
            checks++;
            if (mvalid[i] !== 1'b0 || mdata[i] !== 128'd0 || ovf[i] !== 1'b0 || lcnt[i] !== 12'd0) begin
                errors++;
                $display("FAIL reset_out[%0d] m_valid=%b m_data=%0h ovf=%b line_cnt=%0d, want all 0",
                         i, mvalid[i], mdata[i], ovf[i], lcnt[i]);
            end
        end
        rstn = 3'b111;
        tick();
    endtask

    task automatic test_basic_frame();
        int cyc = 0, post = 0, fs_high = 0, fall_cyc = -1, first_rd = -1;
        int nbeat = 0, last_pop = -1, done_cyc = -1, ndone = 0;
        logic fs_prev = 1'b0;
        mready[0] = 1'b1;
        fstart[0] = 1'b1; tick(); fstart[0] = 1'b0;
        while (cyc < 1000 && post < 3) begin
            if (fsync[0]) fs_high++;
            if (fs_prev && !fsync[0] && fall_cyc < 0) fall_cyc = cyc;
            fs_prev = fsync[0];
            if (rden[0] && first_rd < 0) first_rd = cyc;
            if (mvalid[0] && mready[0]) begin
                checks++;
                if (mdata[0] !== 128'(nbeat) || msof[0] !== (nbeat == 0) ||
                    meol[0] !== (nbeat % 6 == 5) || meof[0] !== (nbeat == 23)) begin
                    errors++;
                    $display("FAIL basic_beat[%0d] data=%0d sof=%b eol=%b eof=%b, want data=%0d sof=%b eol=%b eof=%b",
                             nbeat, mdata[0], msof[0], meol[0], meof[0], nbeat,
                             nbeat == 0, nbeat % 6 == 5, nbeat == 23);
                end
                nbeat++;
                last_pop = cyc;
            end
            if (done[0]) begin ndone++; done_cyc = cyc; end
            if (ndone > 0) post++;
            tick(); cyc++;
        end
        checks++;
        if (fs_high !== 8) begin errors++; $display("FAIL basic_fsync_len got %0d want 8", fs_high); end
        checks++;
        if (first_rd - fall_cyc !== 16) begin
            errors++; $display("FAIL basic_first_rd delay got %0d want 16", first_rd - fall_cyc);
        end
        checks++;
        if (nbeat !== 24) begin errors++; $display("FAIL basic_beats got %0d want 24", nbeat); end
        checks++;
        if (ndone !== 1 || done_cyc - last_pop !== 1) begin
            errors++; $display("FAIL basic_done count=%0d lag=%0d want count=1 lag=1", ndone, done_cyc - last_pop);
        end
        checks++;
        if (lcnt[0] !== 12'd4 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL basic_end line_cnt=%0d busy=%b want 4/0", lcnt[0], busy[0]);
        end
    endtask

    task automatic test_reset_mid_line();
        int cyc = 0;
        mready[0] = 1'b0;
        fstart[0] = 1'b1; tick(); fstart[0] = 1'b0;
        while (cyc < 500 && !(lcnt[0] == 12'd1 && rden[0])) begin
            tick(); cyc++;
        end
        checks++;
        if (cyc >= 500) begin errors++; $display("FAIL midreset_reach_line timeout, second line never issued"); end
        rstn[0] = 1'b0;
        tick();
        checks++;
        if (rden[0] !== 1'b0 || fsync[0] !== 1'b0 || mvalid[0] !== 1'b0 ||
            busy[0] !== 1'b0 || lcnt[0] !== 12'd0) begin
            errors++;
            $display("FAIL midreset rd_en=%b fsync=%b m_valid=%b busy=%b line_cnt=%0d, want all 0",
                     rden[0], fsync[0], mvalid[0], busy[0], lcnt[0]);
        end
        rstn[0] = 1'b1; mready[0] = 1'b1;
        tick();
    endtask

    task automatic test_backpressure();
        int cyc = 0, nbeat = 0, rd_late = 0, ndone = 0, post = 0;
        mready[1] = 1'b1;
        fstart[1] = 1'b1; tick(); fstart[1] = 1'b0;
        while (nbeat < 3 && cyc < 500) begin
            if (mvalid[1]) begin
                checks++;
                if (mdata[1] !== 128'(nbeat) || msof[1] !== (nbeat == 0)) begin
                    errors++; $display("FAIL bp_head[%0d] data=%0d sof=%b want %0d/%b",
                                       nbeat, mdata[1], msof[1], nbeat, nbeat == 0);
                end
                nbeat++;
            end
            tick(); cyc++;
        end
        mready[1] = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c >= 20 && rden[1]) rd_late++;
            tick();
        end
        checks++;
        if (rd_late !== 0 || vdata[1] !== 128'd7 || mvalid[1] !== 1'b1 || ovf[1] !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall rd_en_late=%0d delivered=%0d m_valid=%b ovf=%b want 0/7/1/0",
                     rd_late, vdata[1], mvalid[1], ovf[1]);
        end
        inj[1] = 1'b1; tick(); inj[1] = 1'b0;
        checks++;
        if (ovf[1] !== 1'b1) begin errors++; $display("FAIL bp_ovf_set got %b want 1", ovf[1]); end
        mready[1] = 1'b1;
        cyc = 0;
        while (cyc < 1000 && post < 3) begin
            if (mvalid[1]) begin
                checks++;
                if (mdata[1] !== 128'(nbeat) || meol[1] !== (nbeat % 6 == 5) || meof[1] !== (nbeat == 23)) begin
                    errors++;
                    $display("FAIL bp_beat[%0d] data=%0d eol=%b eof=%b want %0d/%b/%b",
                             nbeat, mdata[1], meol[1], meof[1], nbeat, nbeat % 6 == 5, nbeat == 23);
                end
                nbeat++;
            end
            if (done[1]) ndone++;
            if (ndone > 0) post++;
            tick(); cyc++;
        end
        checks++;
        if (nbeat !== 24 || ndone !== 1 || ovf[1] !== 1'b1) begin
            errors++; $display("FAIL bp_end beats=%0d done=%0d ovf=%b want 24/1/1", nbeat, ndone, ovf[1]);
        end
    endtask

    task automatic test_busy_start();
        int cyc = 0, rises = 0, ndone = 0, nbeat = 0, post = 0;
        logic fs_prev = 1'b0;
        mready[1] = 1'b1;
        fstart[1] = 1'b1; tick(); fstart[1] = 1'b0;
        checks++;
        if (ovf[1] !== 1'b0 || busy[1] !== 1'b1) begin
            errors++; $display("FAIL busy_start_clear ovf=%b busy=%b want 0/1", ovf[1], busy[1]);
        end
        while (cyc < 1000 && post < 5) begin
            fstart[1] = (cyc == 20 || cyc == 45);
            if (fsync[1] && !fs_prev) rises++;
            fs_prev = fsync[1];
            if (mvalid[1]) nbeat++;
            if (done[1]) begin ndone++; fstart[1] = 1'b1; end
            if (ndone > 0) post++;
            tick(); cyc++;
        end
        fstart[1] = 1'b0;
        checks++;
        if (rises !== 1 || ndone !== 1 || nbeat !== 24) begin
            errors++; $display("FAIL busy_ignore fsync_pulses=%0d done=%0d beats=%0d want 1/1/24", rises, ndone, nbeat);
        end
        checks++;
        if (busy[1] !== 1'b0 || fsync[1] !== 1'b0) begin
            errors++; $display("FAIL done_cycle_start busy=%b fsync=%b want 0/0", busy[1], fsync[1]);
        end
    endtask

    task automatic test_random_ready();
        int cyc = 0, nbeat = 0, ndone = 0, post = 0;
        mready[2] = 1'b1;
        fstart[2] = 1'b1; tick(); fstart[2] = 1'b0;
        while (cyc < 3000 && post < 3) begin
            mready[2] = 1'($urandom_range(0, 1));
            if (mvalid[2] && mready[2]) begin
                checks++;
                if (mdata[2] !== 128'(nbeat) || msof[2] !== (nbeat == 0) ||
                    meol[2] !== (nbeat % 6 == 5) || meof[2] !== (nbeat == 47)) begin
                    errors++;
                    $display("FAIL rand_beat[%0d] data=%0d sof=%b eol=%b eof=%b want %0d/%b/%b/%b",
                             nbeat, mdata[2], msof[2], meol[2], meof[2], nbeat,
                             nbeat == 0, nbeat % 6 == 5, nbeat == 47);
                end
                nbeat++;
            end
            if (done[2]) ndone++;
            if (ndone > 0) post++;
            tick(); cyc++;
        end
        mready[2] = 1'b1;
        checks++;
        if (nbeat !== 48 || ndone !== 1 || lcnt[2] !== 12'd8) begin
            errors++; $display("FAIL rand_end beats=%0d done=%0d line_cnt=%0d want 48/1/8", nbeat, ndone, lcnt[2]);
        end
    endtask

    task automatic test_gap0_continuous();
        int cyc = 0, run = 0, max_run = 0, total = 0, ndone = 0, post = 0;
        mready[2] = 1'b1;
        fstart[2] = 1'b1; tick(); fstart[2] = 1'b0;
        while (cyc < 1000 && post < 3) begin
            if (rden[2]) begin
                run++; total++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (done[2]) ndone++;
            if (ndone > 0) post++;
            tick(); cyc++;
        end
        checks++;
        if (max_run !== 48 || total !== 48 || ndone !== 1) begin
            errors++; $display("FAIL gap0_run longest=%0d total=%0d done=%0d want 48/48/1", max_run, total, ndone);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_reset_mid_line();
        test_backpressure();
        test_busy_start();
        test_random_ready();
        test_gap0_continuous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
